regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Clears a register file after reset, then arbitrates write requests from
//   three requesters onto a single register-file write port (round-robin).
//
// Ports
//   CLK        : clock, all state changes on the rising edge
//   Reset      : synchronous, active-high reset
//   Req[2:0]   : per-requester pending-write flag
//   Addr0..2   : target register of requester 0..2
//   Data0..2   : write data of requester 0..2
//   Grant[2:0] : registered one-hot-or-zero acknowledge, high for one cycle
//   Write      : registered register-file write enable
//   WriteAddr  : registered register-file write address
//   DataIn     : registered register-file write data
//   InitDone   : high once the clear sequence has completed
//   state_dbg  : current FSM state (0 = INIT, 1 = RUN)
//
// Handshake: Req[i] acts as a valid that must stay asserted, with Addr/Data
// stable, until the requester observes Grant[i] high; Grant[i] is the ready
// and coincides exactly with the Write cycle carrying requester i's data.
// The requester drops or changes its request on the edge that ends that
// cycle. A requester whose Grant is high is not eligible in that cycle, so
// the same request can never be written twice.

module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [2:0]            Req,
  input  logic [ADDR_WIDTH-1:0] Addr0,
  input  logic [ADDR_WIDTH-1:0] Addr1,
  input  logic [ADDR_WIDTH-1:0] Addr2,
  input  logic [DATA_WIDTH-1:0] Data0,
  input  logic [DATA_WIDTH-1:0] Data1,
  input  logic [DATA_WIDTH-1:0] Data2,
  output logic [2:0]            Grant,
  output logic                  Write,
  output logic [ADDR_WIDTH-1:0] WriteAddr,
  output logic [DATA_WIDTH-1:0] DataIn,
  output logic                  InitDone,
  output logic                  state_dbg
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] count;
  // Set on the edge that clears the last register; the following edge
  // leaves INIT with Write low.
  logic                  clear_done;
  logic [1:0]            ptr;

  logic [2:0]            elig;
  logic                  any_elig;
  logic [1:0]            cand1;
  logic [1:0]            cand2;
  logic [1:0]            winner;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign state_dbg = state;

  // Round-robin search starting at the priority pointer.
  always_comb begin
    elig     = Req & ~Grant;
    any_elig = |elig;
    cand1    = inc3(ptr);
    cand2    = inc3(cand1);
    if (elig[ptr])        winner = ptr;
    else if (elig[cand1]) winner = cand1;
    else                  winner = cand2;
  end

  always_comb begin
    win_addr = Addr0;
    win_data = Data0;
    case (winner)
      2'd1:    begin win_addr = Addr1; win_data = Data1; end
      2'd2:    begin win_addr = Addr2; win_data = Data2; end
      default: begin win_addr = Addr0; win_data = Data0; end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= ST_INIT;
      count      <= '0;
      clear_done <= 1'b0;
      ptr        <= 2'd0;
      Write      <= 1'b0;
      WriteAddr  <= '0;
      DataIn     <= '0;
      Grant      <= 3'b000;
      InitDone   <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          Grant <= 3'b000;
          if (!clear_done) begin
            Write     <= 1'b1;
            WriteAddr <= count;
            DataIn    <= '0;
            count     <= count + 1'b1;
            if (count == '1) clear_done <= 1'b1;
          end else begin
            Write    <= 1'b0;
            InitDone <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (any_elig) begin
            Write     <= 1'b1;
            WriteAddr <= win_addr;
            DataIn    <= win_data;
            Grant     <= 3'b001 << winner;
            ptr       <= inc3(winner);
          end else begin
            // Address and data hold their last values when idle.
            Write <= 1'b0;
            Grant <= 3'b000;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule
